// File: rtl/lsu_pkg.sv
// Shared types for the load/store control stage: access sizes, FSM states and
// response error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StRmwGap,
    StWr,
    StResp
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_e;

  // Illegal size, or an address not naturally aligned to the access size.
  function automatic logic is_misaligned(lsu_size_e size, logic [1:0] addr_lo);
    logic bad;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a memory word and
// merges sub-word store data into a memory word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext_b;
  logic        sext_h;

  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext_b   = ~is_unsigned & byte_sel[7];
    sext_h   = ~is_unsigned & half_sel[15];
  end

  always_comb begin
    load_data = rdata;
    merged    = wdata;
    unique case (size)
      SZ_B: begin
        load_data                        = {{24{sext_b}}, byte_sel};
        merged                           = rdata;
        merged[{addr_lo, 3'b000} +: 8]   = wdata[7:0];
      end
      SZ_H: begin
        load_data                            = {{16{sext_h}}, half_sel};
        merged                               = rdata;
        merged[{addr_lo[1], 4'b0000} +: 16]  = wdata[15:0];
      end
      default: begin
        load_data = rdata;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the mau: checks requests, issues word-aligned
// accesses, extends load data and performs read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DCCM_BYTES     = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_err,
  output logic        access_enable,
  output logic        read_enable,
  output logic        write_enable,
  output logic [31:0] access_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        data_valid,
  input  logic        write_done
);

  localparam int unsigned     CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  lsu_size_e       size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     wword_q, wword_d;
  lsu_err_e        err_q, err_d;

  lsu_size_e   req_sz;
  logic        req_misalign;
  logic        req_range;
  logic        timeout_hit;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  logic        req_ready_c;
  logic        resp_valid_c;
  logic        access_enable_c;
  logic        read_enable_c;
  logic        write_enable_c;
  logic [31:0] access_addr_c;
  logic [31:0] write_data_c;

  assign req_sz       = lsu_size_e'(req_size);
  assign req_misalign = is_misaligned(req_sz, req_addr[1:0]);
  assign req_range    = (req_addr >= DCCM_BYTES);
  assign timeout_hit  = TimeoutEn && (cnt_q == CntLast);

  lsu_byte_lane u_byte_lane (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .rdata      (read_data),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .merged     (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      wword_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      wword_q <= wword_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    size_d          = size_q;
    uns_d           = uns_q;
    wdata_d         = wdata_q;
    rd_d            = rd_q;
    rdata_d         = rdata_q;
    wword_d         = wword_q;
    err_d           = err_q;
    req_ready_c     = 1'b0;
    resp_valid_c    = 1'b0;
    access_enable_c = 1'b0;
    read_enable_c   = 1'b0;
    write_enable_c  = 1'b0;
    access_addr_c   = '0;
    write_data_c    = '0;

    unique case (state_q)
      StIdle: begin
        req_ready_c = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_sz;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          rdata_d = '0;
          err_d   = ERR_OK;
          cnt_d   = '0;
          if (req_misalign) begin
            err_d   = ERR_MISALIGN;
            state_d = StResp;
          end else if (req_range) begin
            err_d   = ERR_RANGE;
            state_d = StResp;
          end else if (!req_is_store) begin
            state_d = StRd;
          end else if (req_sz == SZ_W) begin
            wword_d = req_wdata;
            state_d = StWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end

      StRd, StRmwRd: begin
        access_enable_c = 1'b1;
        read_enable_c   = 1'b1;
        access_addr_c   = {addr_q[31:2], 2'b00};
        if (data_valid) begin
          if (state_q == StRd) begin
            rdata_d = lane_load;
            state_d = StResp;
          end else begin
            wword_d = lane_merged;
            state_d = StRmwGap;
          end
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // Idle cycle so the mau sees a fresh access_enable edge for the write.
      StRmwGap: begin
        cnt_d   = '0;
        state_d = StWr;
      end

      StWr: begin
        access_enable_c = 1'b1;
        write_enable_c  = 1'b1;
        access_addr_c   = {addr_q[31:2], 2'b00};
        write_data_c    = wword_q;
        if (write_done) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StResp: begin
        resp_valid_c = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is asserted, not just after the reset edge.
  assign req_ready     = resetn & req_ready_c;
  assign resp_valid    = resetn & resp_valid_c;
  assign resp_rdata    = resetn ? rdata_q : '0;
  assign resp_rd       = resetn ? rd_q : '0;
  assign resp_err      = resetn ? err_q : ERR_OK;
  assign access_enable = resetn & access_enable_c;
  assign read_enable   = resetn & read_enable_c;
  assign write_enable  = resetn & write_enable_c;
  assign access_addr   = resetn ? access_addr_c : '0;
  assign write_data    = resetn ? write_data_c : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized requests against a
// byte-arithmetic reference model and a small mau memory model.
module tb_lsu_ctrl;

  localparam int unsigned Dccm = 65536;
  localparam int unsigned Tmo  = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        access_enable;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] access_addr;
  logic [31:0] write_data;
  logic [31:0] read_data = '0;
  logic        data_valid = 1'b0;
  logic        write_done = 1'b0;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .DCCM_BYTES    (Dccm),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_err     (resp_err),
    .access_enable(access_enable),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .access_addr  (access_addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .data_valid   (data_valid),
    .write_done   (write_done)
  );

  logic [31:0] mau_mem [64];
  logic [31:0] ref_mem [64];
  bit          stall = 1'b0;
  bit          done_f = 1'b0;
  bit          prev_ae = 1'b0;
  int          lat_cnt = 0;
  int          rises = 0;
  int          ae_cycles = 0;
  int          n_wr = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mau model: random 0..3 cycle latency, one completion per access, plus stray
  // completion pulses of the wrong kind that the DUT must ignore.
  always @(negedge clk) begin
    data_valid = 1'b0;
    write_done = 1'b0;
    if (access_enable && !prev_ae) rises++;
    if (access_enable) ae_cycles++;
    if (access_enable && !done_f && !stall && lat_cnt == 0) begin
      if (read_enable) begin
        read_data  = mau_mem[access_addr[7:2]];
        data_valid = 1'b1;
      end else if (write_enable) begin
        mau_mem[access_addr[7:2]] = write_data;
        write_done = 1'b1;
        n_wr++;
        last_wa = access_addr;
        last_wd = write_data;
      end
      done_f = 1'b1;
    end else begin
      if (access_enable && !done_f && !stall) lat_cnt--;
      if (!(access_enable && read_enable)) data_valid = ($urandom_range(0, 3) == 0);
      if (!(access_enable && write_enable)) write_done = ($urandom_range(0, 3) == 0);
    end
    if (!access_enable) begin
      done_f  = 1'b0;
      lat_cnt = $urandom_range(0, 3);
    end
    prev_ae = access_enable;
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic un, input logic [1:0] off);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!un && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    if (sz == 2'd2) return wd;
    sh   = 8 * off;
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic [1:0] ref_err(input logic [1:0] sz, input logic [31:0] a,
                                         input bit stl);
    if (sz == 2'd3 || (a % (32'd1 << sz)) != 0) return 2'd1;
    if (a >= Dccm) return 2'd2;
    if (stl) return 2'd3;
    return 2'd0;
  endfunction

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input int hold, input logic [31:0] exp_data, input logic [1:0] exp_err,
                       output int lat);
    int guard;
    rises     = 0;
    ae_cycles = 0;
    n_wr      = 0;
    @(negedge clk);
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 200);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, exp_data);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rd", 32'(resp_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_data);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  logic        r_st;
  logic [1:0]  r_sz;
  logic        r_un;
  logic [31:0] r_a;
  logic [31:0] r_wd;
  logic [4:0]  r_rd;
  logic [1:0]  e_err;
  logic [31:0] e_data;
  logic [31:0] e_word;
  int          e_rises;
  int          lat;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mau_mem[i] = $urandom();
      ref_mem[i] = mau_mem[i];
    end

    // Reset behaviour.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_access_enable", 32'(access_enable), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Word store then word load.
    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'hCAFEBABE, 5'd3, 0, 32'h0, 2'd0, lat);
    check("ws_writes", 32'(n_wr), 32'd1);
    check("ws_addr", last_wa, 32'h4);
    check("ws_data", last_wd, 32'hCAFEBABE);
    ref_mem[1] = 32'hCAFEBABE;
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 5'd7, 0, 32'hCAFEBABE, 2'd0, lat);
    check("wl_writes", 32'(n_wr), 32'd0);

    // Sub-word loads with sign/zero extension.
    mau_mem[1] = 32'h11223344;
    ref_mem[1] = 32'h11223344;
    issue(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 5'd1, 0, 32'h00000022, 2'd0, lat);
    mau_mem[1] = 32'h8899AABB;
    ref_mem[1] = 32'h8899AABB;
    issue(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 5'd2, 0, 32'hFFFF8899, 2'd0, lat);
    issue(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 5'd2, 1, 32'h00008899, 2'd0, lat);

    // Byte store via read-modify-write.
    mau_mem[1] = 32'h11223344;
    ref_mem[1] = 32'h11223344;
    issue(1'b1, 2'd0, 1'b0, 32'h5, 32'hAAAAAA55, 5'd9, 0, 32'h0, 2'd0, lat);
    check("rmw_rises", 32'(rises), 32'd2);
    check("rmw_writes", 32'(n_wr), 32'd1);
    check("rmw_addr", last_wa, 32'h4);
    check("rmw_data", last_wd, 32'h11225544);
    ref_mem[1] = 32'h11225544;

    // Misaligned and out-of-range requests.
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 5'd4, 0, 32'h0, 2'd1, lat);
    check("misalign_lat", 32'(lat), 32'd1);
    check("misalign_rises", 32'(rises), 32'd0);
    issue(1'b0, 2'd2, 1'b0, Dccm, 32'h0, 5'd5, 0, 32'h0, 2'd2, lat);
    check("range_lat", 32'(lat), 32'd1);
    check("range_rises", 32'(rises), 32'd0);

    // Timeout with a response held for 5 cycles.
    stall = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5'd6, 5, 32'h0, 2'd3, lat);
    check("tmo_ae_cycles", 32'(ae_cycles), Tmo);
    check("tmo_lat", 32'(lat), Tmo + 1);

    // Reset in the middle of a write.
    @(negedge clk);
    req_is_store = 1'b1;
    req_size     = 2'd2;
    req_addr     = 32'hC;
    req_wdata    = 32'hDEADBEEF;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wr_before_rst", 32'(write_enable), 32'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wr_access_enable", 32'(access_enable), 32'd0);
    check("rst_wr_write_enable", 32'(write_enable), 32'd0);
    check("rst_wr_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_wr_no_resp", 32'(resp_valid), 32'd0);
    check("rst_wr_no_access", 32'(access_enable), 32'd0);
    stall = 1'b0;

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      r_st  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 3));
      r_un  = 1'($urandom_range(0, 1));
      r_a   = ($urandom_range(0, 11) == 0) ? (32'h10000 + $urandom_range(0, 32'hFFFF))
                                           : 32'($urandom_range(0, 255));
      r_wd  = $urandom();
      r_rd  = 5'($urandom_range(0, 31));
      stall = ($urandom_range(0, 15) == 0);
      e_err  = ref_err(r_sz, r_a, stall);
      e_data = '0;
      e_word = '0;
      e_rises = 0;
      if (e_err == 2'd0 || e_err == 2'd3) begin
        e_word = ref_store(ref_mem[r_a[7:2]], r_sz, r_a[1:0], r_wd);
        if (!r_st && e_err == 2'd0) e_data = ref_load(ref_mem[r_a[7:2]], r_sz, r_un, r_a[1:0]);
        e_rises = (r_st && r_sz != 2'd2 && e_err == 2'd0) ? 2 : 1;
      end
      issue(r_st, r_sz, r_un, r_a, r_wd, r_rd, $urandom_range(0, 2), e_data, e_err, lat);
      check("rnd_rises", 32'(rises), 32'(e_rises));
      if (e_err == 2'd1 || e_err == 2'd2) check("rnd_err_lat", 32'(lat), 32'd1);
      if (e_err == 2'd3) check("rnd_tmo_lat", 32'(lat), Tmo + 1);
      if (r_st && e_err == 2'd0) begin
        check("rnd_writes", 32'(n_wr), 32'd1);
        check("rnd_wr_addr", last_wa, {r_a[31:2], 2'b00});
        check("rnd_wr_data", last_wd, e_word);
        ref_mem[r_a[7:2]] = e_word;
      end else begin
        check("rnd_no_write", 32'(n_wr), 32'd0);
      end
      stall = 1'b0;
    end

    for (int i = 0; i < 64; i++) check("mem_final", mau_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
